// File: rtl/msrv32_trap_sequencer.sv
// Trap sequencer for a single-issue RV32 core. It decodes exceptions, interrupts
// and mret, and steps through one-cycle trap entry and trap return.
module msrv32_trap_sequencer (
  input  logic       ms_riscv32_mp_clk_in,
  input  logic       ms_riscv32_mp_rst_n_in,
  input  logic       hold_in,
  // Decode
  input  logic       illegal_instr_in,
  input  logic       misaligned_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic [4:0] opcode_6_to_2_in,
  input  logic [2:0] funct3_in,
  input  logic [6:0] funct7_in,
  input  logic [4:0] rs1_addr_in,
  input  logic [4:0] rs2_addr_in,
  input  logic [4:0] rd_addr_in,
  // Interrupts
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       meip_in,
  input  logic       mtip_in,
  input  logic       msip_in,
  // Control outputs
  output logic       trap_taken_out,
  output logic       i_or_e_out,
  output logic [3:0] cause_out,
  output logic       set_cause_out,
  output logic       set_epc_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       instret_inc_out,
  output logic       flush_out,
  output logic [1:0] pc_src_out
);

  typedef enum logic [1:0] {
    StReset      = 2'd0,
    StOperating  = 2'd1,
    StTrapTaken  = 2'd2,
    StTrapReturn = 2'd3
  } state_e;

  localparam logic [1:0] PcBoot  = 2'b00;
  localparam logic [1:0] PcEpc   = 2'b01;
  localparam logic [1:0] PcNext  = 2'b10;
  localparam logic [1:0] PcTrap  = 2'b11;

  state_e     r_state;
  state_e     w_state_next;
  logic [3:0] r_cause;
  logic [3:0] w_cause_next;
  logic       r_i_or_e;
  logic       w_i_or_e_next;

  logic       w_sys_base;
  logic       w_ecall;
  logic       w_ebreak;
  logic       w_mret;
  logic       w_exception;
  logic       w_int_ext;
  logic       w_int_sw;
  logic       w_int_tmr;
  logic       w_interrupt;
  logic [3:0] w_trap_cause;

  // SYSTEM instructions with all register fields zero except rs2, which selects the function
  assign w_sys_base = (opcode_6_to_2_in == 5'b11100) && (funct3_in == 3'b000) &&
                      (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
  assign w_ecall    = w_sys_base && (funct7_in == 7'd0) && (rs2_addr_in == 5'd0);
  assign w_ebreak   = w_sys_base && (funct7_in == 7'd0) && (rs2_addr_in == 5'd1);
  assign w_mret     = w_sys_base && (funct7_in == 7'b0011000) && (rs2_addr_in == 5'd2);

  assign w_exception = illegal_instr_in | misaligned_instr_in | misaligned_load_in |
                       misaligned_store_in | w_ecall | w_ebreak;

  assign w_int_ext   = meie_in & meip_in;
  assign w_int_sw    = msie_in & msip_in;
  assign w_int_tmr   = mtie_in & mtip_in;
  assign w_interrupt = mie_in & (w_int_ext | w_int_sw | w_int_tmr);

  // Cause encoding: exceptions outrank interrupts, each group has a fixed order
  always_comb begin
    w_trap_cause = 4'd0;
    if (w_exception) begin
      if (misaligned_instr_in)      w_trap_cause = 4'd0;
      else if (illegal_instr_in)    w_trap_cause = 4'd2;
      else if (w_ebreak)            w_trap_cause = 4'd3;
      else if (misaligned_load_in)  w_trap_cause = 4'd4;
      else if (misaligned_store_in) w_trap_cause = 4'd6;
      else                          w_trap_cause = 4'd11;
    end else begin
      if (w_int_ext)                w_trap_cause = 4'd11;
      else if (w_int_sw)            w_trap_cause = 4'd3;
      else                          w_trap_cause = 4'd7;
    end
  end

  // State and captured trap cause; async reset abandons any trap in flight
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      r_state  <= StReset;
      r_cause  <= 4'd0;
      r_i_or_e <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cause  <= w_cause_next;
      r_i_or_e <= w_i_or_e_next;
    end
  end

  // Next state and per-state outputs
  always_comb begin
    w_state_next    = r_state;
    w_cause_next    = r_cause;
    w_i_or_e_next   = r_i_or_e;
    trap_taken_out  = 1'b0;
    set_cause_out   = 1'b0;
    set_epc_out     = 1'b0;
    mie_clear_out   = 1'b0;
    mie_set_out     = 1'b0;
    instret_inc_out = 1'b0;
    flush_out       = 1'b0;
    pc_src_out      = PcNext;
    unique case (r_state)
      StReset: begin
        flush_out    = 1'b1;
        pc_src_out   = PcBoot;
        w_state_next = StOperating;
      end
      StOperating: begin
        // Hold freezes everything; a pending trap is simply seen again later
        if (!hold_in) begin
          if (w_exception || w_interrupt) begin
            trap_taken_out = 1'b1;
            w_state_next   = StTrapTaken;
            w_cause_next   = w_trap_cause;
            w_i_or_e_next  = ~w_exception;
          end else if (w_mret) begin
            w_state_next = StTrapReturn;
          end else begin
            instret_inc_out = 1'b1;
          end
        end
      end
      StTrapTaken: begin
        set_cause_out = 1'b1;
        set_epc_out   = 1'b1;
        mie_clear_out = 1'b1;
        flush_out     = 1'b1;
        pc_src_out    = PcTrap;
        w_state_next  = StOperating;
      end
      StTrapReturn: begin
        mie_set_out  = 1'b1;
        flush_out    = 1'b1;
        pc_src_out   = PcEpc;
        w_state_next = StOperating;
      end
      default: w_state_next = StReset;
    endcase
  end

  assign cause_out  = r_cause;
  assign i_or_e_out = r_i_or_e;

endmodule

// File: tb/tb_msrv32_trap_sequencer.sv
// Bench for msrv32_trap_sequencer: directed scenarios then random stimulus,
// all checked against a behavioural model of the trap rules.
module tb_msrv32_trap_sequencer;

  logic       clk;
  logic       rst_n;
  logic       hold;
  logic       illegal, mis_i, mis_l, mis_s;
  logic [4:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rs1, rs2, rd;
  logic       mie, meie, mtie, msie, meip, mtip, msip;

  logic       trap_taken, i_or_e, set_cause, set_epc, mie_clear, mie_set, instret, flush;
  logic [3:0] cause;
  logic [1:0] pc_src;

  msrv32_trap_sequencer dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .hold_in                (hold),
    .illegal_instr_in       (illegal),
    .misaligned_instr_in    (mis_i),
    .misaligned_load_in     (mis_l),
    .misaligned_store_in    (mis_s),
    .opcode_6_to_2_in       (opc),
    .funct3_in              (f3),
    .funct7_in              (f7),
    .rs1_addr_in            (rs1),
    .rs2_addr_in            (rs2),
    .rd_addr_in             (rd),
    .mie_in                 (mie),
    .meie_in                (meie),
    .mtie_in                (mtie),
    .msie_in                (msie),
    .meip_in                (meip),
    .mtip_in                (mtip),
    .msip_in                (msip),
    .trap_taken_out         (trap_taken),
    .i_or_e_out             (i_or_e),
    .cause_out              (cause),
    .set_cause_out          (set_cause),
    .set_epc_out            (set_epc),
    .mie_clear_out          (mie_clear),
    .mie_set_out            (mie_set),
    .instret_inc_out        (instret),
    .flush_out              (flush),
    .pc_src_out             (pc_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] InstrEcall  = 32'h0000_0073;
  localparam logic [31:0] InstrEbreak = 32'h0010_0073;
  localparam logic [31:0] InstrMret   = 32'h3020_0073;
  localparam logic [31:0] InstrNop    = 32'h0000_0013;

  // Model: where the core is in the trap flow, plus the last recorded trap
  typedef enum int {MReset, MOper, MTrap, MRet} mode_e;
  mode_e      m_mode;
  logic [3:0] m_cause;
  logic       m_ioe;

  // Model verdict on the current inputs
  logic       e_trap;
  logic       e_mret;
  logic [3:0] e_cause;
  logic       e_ioe;

  int n_checks;
  int n_fail;

  task automatic set_instr(input logic [31:0] w);
    f7  = w[31:25];
    rs2 = w[24:20];
    rs1 = w[19:15];
    f3  = w[14:12];
    rd  = w[11:7];
    opc = w[6:2];
  endtask

  task automatic clear_inputs();
    hold = 1'b0;
    {illegal, mis_i, mis_l, mis_s} = 4'b0;
    {mie, meie, mtie, msie, meip, mtip, msip} = 7'b0;
    set_instr(InstrNop);
  endtask

  // Trap rules from the architecture: full-word instruction match, ordered cause tables
  task automatic evaluate();
    logic [31:0] word;
    logic        exc_flags[6];
    int          exc_codes[6];
    logic        int_flags[3];
    int          int_codes[3];
    logic        exc_any, int_any;
    word = {f7, rs2, rs1, f3, rd, opc, 2'b11};
    exc_flags = '{mis_i, illegal, word == InstrEbreak, mis_l, mis_s, word == InstrEcall};
    exc_codes = '{0, 2, 3, 4, 6, 11};
    int_flags = '{meie && meip, msie && msip, mtie && mtip};
    int_codes = '{11, 3, 7};
    exc_any = 1'b0;
    int_any = 1'b0;
    e_cause = 4'd0;
    for (int i = 5; i >= 0; i--) if (exc_flags[i]) begin exc_any = 1'b1; e_cause = 4'(exc_codes[i]); end
    if (!exc_any && mie) begin
      for (int i = 2; i >= 0; i--) if (int_flags[i]) begin int_any = 1'b1; e_cause = 4'(int_codes[i]); end
    end
    e_ioe  = !exc_any;
    e_trap = (m_mode == MOper) && !hold && (exc_any || int_any);
    e_mret = (word == InstrMret);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] x_pc, x_flush, x_sc, x_mc, x_ms, x_inst;
    evaluate();
    x_pc = 4'd2; x_flush = 0; x_sc = 0; x_mc = 0; x_ms = 0; x_inst = 0;
    case (m_mode)
      MReset: begin x_pc = 4'd0; x_flush = 1; end
      MOper:  x_inst = {3'b0, !hold && !e_trap && !e_mret};
      MTrap:  begin x_pc = 4'd3; x_flush = 1; x_sc = 1; x_mc = 1; end
      MRet:   begin x_pc = 4'd1; x_flush = 1; x_ms = 1; end
      default: ;
    endcase
    chk({tag, ".trap_taken"}, {3'b0, trap_taken}, {3'b0, e_trap});
    chk({tag, ".cause"},      cause,              m_cause);
    chk({tag, ".i_or_e"},     {3'b0, i_or_e},     {3'b0, m_ioe});
    chk({tag, ".set_cause"},  {3'b0, set_cause},  x_sc);
    chk({tag, ".set_epc"},    {3'b0, set_epc},    x_sc);
    chk({tag, ".mie_clear"},  {3'b0, mie_clear},  x_mc);
    chk({tag, ".mie_set"},    {3'b0, mie_set},    x_ms);
    chk({tag, ".instret"},    {3'b0, instret},    x_inst);
    chk({tag, ".flush"},      {3'b0, flush},      x_flush);
    chk({tag, ".pc_src"},     {2'b0, pc_src},     x_pc);
  endtask

  task automatic model_reset();
    m_mode  = MReset;
    m_cause = 4'd0;
    m_ioe   = 1'b0;
  endtask

  // Advance one clock; the model moves with the same inputs the DUT saw
  task automatic tick();
    evaluate();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      case (m_mode)
        MReset: m_mode = MOper;
        MOper: if (!hold) begin
          if (e_trap) begin m_mode = MTrap; m_cause = e_cause; m_ioe = e_ioe; end
          else if (e_mret) m_mode = MRet;
        end
        default: m_mode = MOper;
      endcase
    end
    #1;
  endtask

  task automatic step(input string tag);
    #2;
    check_all(tag);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_inputs();
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick();
    tick();
    step("in_reset");
    rst_n = 1'b1;
    step("reset_cycle");
    step("first_oper");

    // Illegal instruction trap entry
    illegal = 1'b1;
    step("illegal_detect");
    illegal = 1'b0;
    #2 chk("illegal_cause_const", cause, 4'd2);
    step("illegal_trap_cycle");
    step("after_illegal");

    // Two interrupts pending: external outranks timer; then globally masked
    {mie, meie, meip, mtie, mtip} = 5'b11111;
    step("int_detect");
    {mie, meie, meip, mtie, mtip} = 5'b0;
    #2 chk("int_cause_const", cause, 4'd11);
    chk("int_ioe_const", {3'b0, i_or_e}, 4'd1);
    step("int_trap_cycle");
    {mie, meie, meip, mtie, mtip} = 5'b01111;
    step("int_masked");
    clear_inputs();

    // ecall beats a pending external interrupt
    set_instr(InstrEcall);
    {mie, meie, meip} = 3'b111;
    step("ecall_vs_int");
    clear_inputs();
    #2 chk("ecall_ioe_const", {3'b0, i_or_e}, 4'd0);
    step("ecall_trap_cycle");

    // mret
    set_instr(InstrMret);
    step("mret_detect");
    set_instr(InstrNop);
    step("mret_return_cycle");
    step("after_mret");

    // Held misaligned load, then release, then reset in the trap cycle
    hold  = 1'b1;
    mis_l = 1'b1;
    step("hold_1");
    step("hold_2");
    hold = 1'b0;
    step("hold_release");
    mis_l = 1'b0;
    #1;
    chk("mis_load_cause_const", cause, 4'd4);
    rst_n = 1'b0;
    model_reset();
    #1 check_all("reset_in_trap");
    tick();
    rst_n = 1'b1;
    step("release_after_trap");
    step("oper_after_trap_reset");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int pick;
      hold    = ($urandom_range(0, 7) == 0);
      illegal = ($urandom_range(0, 15) == 0);
      mis_i   = ($urandom_range(0, 15) == 0);
      mis_l   = ($urandom_range(0, 15) == 0);
      mis_s   = ($urandom_range(0, 15) == 0);
      mie     = $urandom_range(0, 1) == 1;
      meie    = $urandom_range(0, 3) == 0;
      meip    = $urandom_range(0, 1) == 1;
      msie    = $urandom_range(0, 3) == 0;
      msip    = $urandom_range(0, 1) == 1;
      mtie    = $urandom_range(0, 3) == 0;
      mtip    = $urandom_range(0, 1) == 1;
      pick    = int'($urandom_range(0, 5));
      case (pick)
        0: set_instr(InstrEcall);
        1: set_instr(InstrEbreak);
        2: set_instr(InstrMret);
        3: set_instr($urandom());
        4: set_instr(InstrMret ^ (32'h1 << $urandom_range(7, 31)));
        default: set_instr(InstrNop);
      endcase
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msrv32_trap_sequencer.md
MSRV32_TRAP_SEQUENCER -- requirements
Module: msrv32_trap_sequencer

Interface
REQ-001 SHALL have port ms_riscv32_mp_clk_in, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port ms_riscv32_mp_rst_n_in, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port hold_in, input, 1: pipeline stall; 1 freezes state and suppresses all pulses.
REQ-004 SHALL have the following decode inputs: illegal_instr_in 1, misaligned_instr_in 1, misaligned_load_in 1, misaligned_store_in 1, opcode_6_to_2_in 5, funct3_in 3, funct7_in 7, rs1_addr_in 5, rs2_addr_in 5, rd_addr_in 5.
REQ-005 SHALL have the following interrupt inputs, each 1 bit: mie_in (global enable), meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in.
REQ-006 SHALL have the following outputs: trap_taken_out 1, i_or_e_out 1 (1=interrupt), cause_out 4, set_cause_out 1, set_epc_out 1, mie_clear_out 1, mie_set_out 1, instret_inc_out 1, flush_out 1, pc_src_out 2.

Function
REQ-007 SHALL implement states RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN.
REQ-008 SHALL move RESET->OPERATING on the first clock edge after reset release, regardless of hold_in.
REQ-009 SHALL decode the following SYSTEM instructions (opcode_6_to_2_in=11100, funct3=000, rs1=0, rd=0):
- ecall: funct7=0, rs2=0.
- ebreak: funct7=0, rs2=1.
- mret: funct7=0011000, rs2=2.
REQ-010 SHALL define exception = illegal | misaligned_instr | misaligned_load | misaligned_store | ecall | ebreak.
REQ-011 SHALL define interrupt = mie_in & ((meie&meip) | (msie&msip) | (mtie&mtip)).
REQ-012 SHALL assert trap_taken_out combinationally in OPERATING when hold_in=0 and (exception | interrupt); it is 0 in all other states.
REQ-013 SHALL, in OPERATING with hold_in=0, transition as follows:
- trap_taken_out=1 -> TRAP_TAKEN.
- else mret -> TRAP_RETURN.
- else stay in OPERATING.
REQ-014 SHALL give exceptions priority over interrupts when both are present in the same cycle.
REQ-015 SHALL apply this exception priority, highest first: misaligned_instr(0) > illegal(2) > ebreak(3) > misaligned_load(4) > misaligned_store(6) > ecall(11).
REQ-016 SHALL apply this interrupt priority, highest first: external(11) > software(3) > timer(7).
REQ-017 SHALL register cause_out and i_or_e_out on the OPERATING->TRAP_TAKEN edge and hold them until the next trap.
REQ-018 SHALL, while in TRAP_TAKEN, drive set_cause_out=1, set_epc_out=1, mie_clear_out=1, flush_out=1 and pc_src_out=11 (trap vector) for exactly one cycle, then go to OPERATING.
REQ-019 SHALL, while in TRAP_RETURN, drive mie_set_out=1, flush_out=1 and pc_src_out=01 (mepc) for exactly one cycle, then go to OPERATING.
REQ-020 SHALL drive pc_src_out=00 (boot address) and flush_out=1 in RESET, and pc_src_out=10 (next pc) in OPERATING.
REQ-021 SHALL assert instret_inc_out only in OPERATING with hold_in=0, no trap and no mret.
REQ-022 SHALL, on hold_in=1 in OPERATING, keep the state and hold all pulse outputs at 0; pending traps are re-evaluated when hold drops.
REQ-023 SHALL complete TRAP_TAKEN and TRAP_RETURN regardless of hold_in, since both states last one cycle only.
REQ-024 SHALL ignore interrupt and exception inputs in RESET, TRAP_TAKEN and TRAP_RETURN.

Reset
REQ-025 SHALL, on ms_riscv32_mp_rst_n_in=0, immediately and asynchronously enter RESET from any state.
REQ-026 SHALL, during reset, drive cause_out=0, i_or_e_out=0 and every pulse output=0, except flush_out=1 and pc_src_out=00.
REQ-027 SHALL, on reset asserted in TRAP_TAKEN, abandon the trap with no set_cause/set_epc pulse after release.

Verification
REQ-028 SHALL pass this scenario: reset release -> exactly one RESET cycle (flush=1, pc_src=00), then OPERATING with pc_src=10 and instret_inc=1.
REQ-029 SHALL pass this scenario: illegal_instr_in=1 in OPERATING -> trap_taken=1 that cycle; next cycle cause=2, i_or_e=0, set_cause/set_epc/mie_clear=1, pc_src=11; following cycle OPERATING.
REQ-030 SHALL pass this scenario: mie=1, meie=meip=1, mtie=mtip=1 -> cause=11, i_or_e=1; with mie=0 -> no trap.
REQ-031 SHALL pass this scenario: ecall together with meip/meie/mie=1 -> exception wins, cause=11, i_or_e=0.
REQ-032 SHALL pass this scenario: mret (funct7=0011000, rs2=2) -> one TRAP_RETURN cycle with mie_set=1, pc_src=01, instret_inc=0.
REQ-033 SHALL pass this scenario: hold_in=1 with misaligned_load=1 -> no trap and no pulses; hold_in drops -> cause=4 trap taken; reset asserted in TRAP_TAKEN -> RESET outputs immediately.
